// File: rtl/aidan_mcnay_prime_pkg.sv
// Shared state encoding and default widths for the
// trial-division prime controller.
package aidan_mcnay_prime_pkg;

   localparam int STATE_W    = 3;
   localparam int NBITS_DEF  = 16;
   localparam int ITER_W_DEF = 16;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_DIV_REQ  = 3'd2,
      S_DIV_RESP = 3'd3,
      S_STEP     = 3'd4,
      S_DONE     = 3'd5,
      S_DRAIN    = 3'd6
   } state_e;

endpackage

// File: rtl/aidan_mcnay_prime_ctrl_v2_if.sv
// Request, divider and response streams of the prime
// controller; master is the environment, slave the block.
interface aidan_mcnay_prime_ctrl_v2_if
   import aidan_mcnay_prime_pkg::*;
#(
   parameter int NBITS  = NBITS_DEF,
   parameter int ITER_W = ITER_W_DEF
);

   logic              req_val;
   logic              req_rdy;
   logic [NBITS-1:0]  req_value;
   logic              abort;
   logic              div_req_val;
   logic              div_req_rdy;
   logic [NBITS-1:0]  div_dividend;
   logic [NBITS-1:0]  div_divisor;
   logic              div_resp_val;
   logic              div_resp_rdy;
   logic [NBITS-1:0]  div_quot;
   logic [NBITS-1:0]  div_rem;
   logic              resp_val;
   logic              resp_rdy;
   logic              resp_is_prime;
   logic [NBITS-1:0]  resp_factor;
   logic [ITER_W-1:0] resp_iters;
   logic              busy;

   modport master (
      output req_val, req_value, abort,
      output div_req_rdy, div_resp_val,
      output div_quot, div_rem, resp_rdy,
      input  req_rdy, div_req_val,
      input  div_dividend, div_divisor,
      input  div_resp_rdy, resp_val,
      input  resp_is_prime, resp_factor,
      input  resp_iters, busy
   );

   modport slave (
      input  req_val, req_value, abort,
      input  div_req_rdy, div_resp_val,
      input  div_quot, div_rem, resp_rdy,
      output req_rdy, div_req_val,
      output div_dividend, div_divisor,
      output div_resp_rdy, resp_val,
      output resp_is_prime, resp_factor,
      output resp_iters, busy
   );

endinterface

// File: rtl/aidan_mcnay_divisor_step.sv
// Trial divisor register: loads 2 on a new value and
// advances to the next candidate divisor on step.
module aidan_mcnay_divisor_step
   import aidan_mcnay_prime_pkg::*;
#(
   parameter int NBITS    = NBITS_DEF,
   parameter bit ODD_ONLY = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load2,
   input  logic             i_step,
   output logic [NBITS-1:0] o_divisor
);

   logic [NBITS-1:0] r_div;
   logic [NBITS-1:0] w_next;

   // With ODD_ONLY the sequence is 2,3,5,7,...
   always_comb begin
      w_next = r_div;
      if (i_load2) begin
         w_next = NBITS'(2);
      end else if (i_step) begin
         if (ODD_ONLY) begin
            w_next = (r_div == NBITS'(2)) ?
                     NBITS'(3) : r_div + NBITS'(2);
         end else begin
            w_next = r_div + NBITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_div <= NBITS'(2);
      else       r_div <= w_next;
   end

   assign o_divisor = r_div;

endmodule

// File: rtl/aidan_mcnay_prime_ctrl_v2.sv
// Trial-division prime detector control with an external
// val/rdy divider, early exit, abort and divider drain.
module aidan_mcnay_prime_ctrl_v2
   import aidan_mcnay_prime_pkg::*;
#(
   parameter int NBITS    = NBITS_DEF,
   parameter bit ODD_ONLY = 1'b1,
   parameter int ITER_W   = ITER_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   aidan_mcnay_prime_ctrl_v2_if.slave  io_bus
);

   state_e            r_state;
   state_e            w_next;
   logic [NBITS-1:0]  r_value;
   logic [ITER_W-1:0] r_iters;
   logic              r_is_prime;
   logic [NBITS-1:0]  r_factor;
   logic [NBITS-1:0]  w_divisor;
   logic              w_latch;
   logic              w_load2;
   logic              w_step;
   logic              w_inc;
   logic              w_set;
   logic              w_prime;
   logic [NBITS-1:0]  w_factor;

   aidan_mcnay_divisor_step #(
      .NBITS    (NBITS),
      .ODD_ONLY (ODD_ONLY)
   ) u_divisor (
      .clk       (clk),
      .reset     (reset),
      .i_load2   (w_load2),
      .i_step    (w_step),
      .o_divisor (w_divisor)
   );

   always_comb begin
      w_next   = r_state;
      w_latch  = 1'b0;
      w_load2  = 1'b0;
      w_step   = 1'b0;
      w_inc    = 1'b0;
      w_set    = 1'b0;
      w_prime  = 1'b0;
      w_factor = '0;
      unique case (r_state)
         S_IDLE: begin
            if (io_bus.req_val) begin
               w_latch = 1'b1;
               w_load2 = 1'b1;
               w_next  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (io_bus.abort) begin
               w_next = S_IDLE;
            end else if (r_value < NBITS'(2)) begin
               w_set  = 1'b1;
               w_next = S_DONE;
            end else if (r_value < NBITS'(4)) begin
               w_set   = 1'b1;
               w_prime = 1'b1;
               w_next  = S_DONE;
            end else begin
               w_next = S_DIV_REQ;
            end
         end
         S_DIV_REQ: begin
            if (io_bus.div_req_rdy)
               w_next = io_bus.abort ? S_DRAIN : S_DIV_RESP;
            else if (io_bus.abort)
               w_next = S_IDLE;
         end
         S_DIV_RESP: begin
            if (io_bus.div_resp_val) begin
               if (io_bus.abort) begin
                  w_next = S_IDLE;
               end else begin
                  w_inc = 1'b1;
                  if (io_bus.div_rem == '0) begin
                     w_set    = 1'b1;
                     w_factor = w_divisor;
                     w_next   = S_DONE;
                  end else if (io_bus.div_quot <= w_divisor) begin
                     // divisor^2 already exceeds the value
                     w_set   = 1'b1;
                     w_prime = 1'b1;
                     w_next  = S_DONE;
                  end else begin
                     w_next = S_STEP;
                  end
               end
            end else if (io_bus.abort) begin
               w_next = S_DRAIN;
            end
         end
         S_STEP: begin
            if (io_bus.abort) begin
               w_next = S_IDLE;
            end else begin
               w_step = 1'b1;
               w_next = S_DIV_REQ;
            end
         end
         S_DONE: begin
            if (io_bus.resp_rdy) w_next = S_IDLE;
         end
         S_DRAIN: begin
            if (io_bus.div_resp_val) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_value    <= '0;
         r_iters    <= '0;
         r_is_prime <= 1'b0;
         r_factor   <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_value <= io_bus.req_value;
            r_iters <= '0;
         end else if (w_inc && (r_iters != '1)) begin
            r_iters <= r_iters + ITER_W'(1);
         end
         if (w_set) begin
            r_is_prime <= w_prime;
            r_factor   <= w_factor;
         end
      end
   end

   assign io_bus.req_rdy       = (r_state == S_IDLE);
   assign io_bus.div_req_val   = (r_state == S_DIV_REQ);
   assign io_bus.div_resp_rdy  = (r_state == S_DIV_RESP) ||
                                 (r_state == S_DRAIN);
   assign io_bus.resp_val      = (r_state == S_DONE);
   assign io_bus.busy          = (r_state != S_IDLE);
   assign io_bus.div_dividend  = r_value;
   assign io_bus.div_divisor   = w_divisor;
   assign io_bus.resp_is_prime = r_is_prime;
   assign io_bus.resp_factor   = r_factor;
   assign io_bus.resp_iters    = r_iters;

endmodule

// File: tb/tb_aidan_mcnay_prime_ctrl_v2.sv
// Scoreboard bench: instance 0 ODD_ONLY=1, instance 1
// ODD_ONLY=0, each with a behavioural val/rdy divider.
module tb_aidan_mcnay_prime_ctrl_v2;

   localparam int NB = 16;
   localparam int IW = 16;

   typedef struct {
      int inst;
      bit prime;
      int factor;
      int iters;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic [1:0]    req_val   = '0;
   logic [1:0]    abort     = '0;
   logic [NB-1:0] req_value = '0;
   logic          resp_rdy  = 1'b1;
   int            div_lat   = 3;
   int            div_stall = 0;

   always #5 clk = ~clk;

   function automatic void chk(string name, longint act,
                               longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      aidan_mcnay_prime_ctrl_v2_if #(
         .NBITS(NB), .ITER_W(IW)) ifc ();

      aidan_mcnay_prime_ctrl_v2 #(
         .NBITS    (NB),
         .ODD_ONLY ((g == 0) ? 1'b1 : 1'b0),
         .ITER_W   (IW)
      ) dut (
         .clk    (clk),
         .reset  (reset),
         .io_bus (ifc)
      );

      assign ifc.req_val   = req_val[g];
      assign ifc.req_value = req_value;
      assign ifc.abort     = abort[g];
      assign ifc.resp_rdy  = resp_rdy;

      initial begin : divider
         int cnt, wcnt;
         bit pend, req_hs, rsp_hs, held;
         logic [NB-1:0] dd, dv, hd, hv, q, r;
         ifc.div_req_rdy  = 1'b0;
         ifc.div_resp_val = 1'b0;
         ifc.div_quot     = '0;
         ifc.div_rem      = '0;
         cnt = 0; wcnt = 0; pend = 0; held = 0;
         q = '0; r = '0; hd = '0; hv = '0;
         forever begin
            @(posedge clk);
            req_hs = ifc.div_req_val && ifc.div_req_rdy;
            rsp_hs = ifc.div_resp_val && ifc.div_resp_rdy;
            dd = ifc.div_dividend;
            dv = ifc.div_divisor;
            if (ifc.div_req_val) begin
               if (held) begin
                  chk("div_dividend_stable", dd, hd);
                  chk("div_divisor_stable", dv, hv);
               end
               held = !ifc.div_req_rdy;
               hd = dd; hv = dv;
            end else begin
               held = 0;
            end
            #1;
            if (rsp_hs) ifc.div_resp_val = 1'b0;
            if (req_hs && dv != '0) begin
               q = dd / dv; r = dd % dv;
               cnt = div_lat; pend = 1; wcnt = 0;
            end
            if (pend) begin
               if (cnt > 1) begin
                  cnt--;
               end else begin
                  ifc.div_quot     = q;
                  ifc.div_rem      = r;
                  ifc.div_resp_val = 1'b1;
                  pend = 0;
               end
            end
            if (ifc.div_req_val) begin
               ifc.div_req_rdy = (wcnt >= div_stall);
               if (wcnt < div_stall) wcnt++;
            end else begin
               ifc.div_req_rdy = 1'b0;
               wcnt = 0;
            end
         end
      end

      initial begin : monitor
         bit hold, hp;
         logic [NB-1:0] hf;
         logic [IW-1:0] hi;
         exp_t e;
         hold = 0; hp = 0; hf = '0; hi = '0;
         forever begin
            @(posedge clk);
            if (!reset && ifc.resp_val) begin
               if (hold) begin
                  chk("resp_prime_stable", ifc.resp_is_prime, hp);
                  chk("resp_factor_stable", ifc.resp_factor, hf);
                  chk("resp_iters_stable", ifc.resp_iters, hi);
               end
               if (ifc.resp_rdy) begin
                  hold = 0;
                  if (exp_q.size() == 0) begin
                     chk("unexpected_resp", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("resp_inst", g, e.inst);
                     chk("resp_is_prime", ifc.resp_is_prime, e.prime);
                     chk("resp_factor", ifc.resp_factor, e.factor);
                     chk("resp_iters", ifc.resp_iters, e.iters);
                  end
               end else begin
                  hold = 1;
                  hp = ifc.resp_is_prime;
                  hf = ifc.resp_factor;
                  hi = ifc.resp_iters;
               end
            end else begin
               hold = 0;
            end
         end
      end
   end

   function automatic logic rdy_of(int i);
      return (i == 0) ? g_dut[0].ifc.req_rdy
                      : g_dut[1].ifc.req_rdy;
   endfunction

   task automatic req(int inst, int v);
      int n = 0;
      req_value = NB'(v);
      req_val[inst] = 1'b1;
      forever begin
         @(posedge clk);
         n++;
         if (rdy_of(inst)) break;
         if (n > 100) begin
            chk("req_accept_timeout", n, 0);
            break;
         end
      end
      #1 req_val[inst] = 1'b0;
   endtask

   task automatic send(int inst, int v, bit p, int f, int it);
      exp_t e;
      e.inst = inst; e.prime = p; e.factor = f; e.iters = it;
      exp_q.push_back(e);
      req(inst, v);
   endtask

   task automatic wait_done(int limit);
      int n = 0;
      while (exp_q.size() != 0 || g_dut[0].ifc.busy ||
             g_dut[1].ifc.busy) begin
         @(posedge clk);
         #1;
         n++;
         if (n > limit) begin
            chk("done_timeout", n, limit);
            exp_q.delete();
            break;
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit hs;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_rdy", g_dut[0].ifc.req_rdy, 1);
      chk("rst_div_req_val", g_dut[0].ifc.div_req_val, 0);
      chk("rst_div_resp_rdy", g_dut[0].ifc.div_resp_rdy, 0);
      chk("rst_resp_val", g_dut[0].ifc.resp_val, 0);
      chk("rst_busy", g_dut[0].ifc.busy, 0);
      chk("rst_is_prime", g_dut[0].ifc.resp_is_prime, 0);
      chk("rst_factor", g_dut[0].ifc.resp_factor, 0);
      chk("rst_iters", g_dut[0].ifc.resp_iters, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      div_lat = 3;
      send(0, 97, 1, 0, 6);
      wait_done(500);
      send(0, 91, 0, 7, 4);
      wait_done(500);

      for (int v = 0; v < 4; v++) begin
         send(0, v, (v >= 2), 0, 0);
         chk("small_resp_val_early", g_dut[0].ifc.resp_val, 0);
         @(posedge clk);
         #1;
         chk("small_resp_val_2cyc", g_dut[0].ifc.resp_val, 1);
         wait_done(50);
      end

      send(0, 65521, 1, 0, 129);
      wait_done(3000);
      send(1, 65521, 1, 0, 255);
      wait_done(3000);
      send(0, 65535, 0, 3, 2);
      wait_done(500);

      // abort while the divider still holds its result
      div_lat = 4;
      req(0, 91);
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         n++;
         if (g_dut[0].ifc.div_resp_rdy) break;
         if (n > 100) begin
            chk("abort_reach_resp_timeout", n, 0);
            break;
         end
      end
      abort[0] = 1'b1;
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      chk("drain_resp_rdy", g_dut[0].ifc.div_resp_rdy, 1);
      chk("drain_busy", g_dut[0].ifc.busy, 1);
      chk("drain_req_rdy_low", g_dut[0].ifc.req_rdy, 0);
      n = 0;
      forever begin
         @(posedge clk);
         hs = g_dut[0].ifc.div_resp_val &&
              g_dut[0].ifc.div_resp_rdy;
         #1;
         n++;
         if (hs) break;
         if (n > 100) begin
            chk("drain_timeout", n, 0);
            break;
         end
      end
      chk("drain_req_rdy_after", g_dut[0].ifc.req_rdy, 1);
      chk("drain_resp_val", g_dut[0].ifc.resp_val, 0);
      wait_done(50);

      // consumer and divider back-pressure
      div_lat   = 3;
      div_stall = 3;
      resp_rdy  = 1'b0;
      send(0, 91, 0, 7, 4);
      n = 0;
      while (!g_dut[0].ifc.resp_val) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 500) begin
            chk("stall_resp_timeout", n, 0);
            break;
         end
      end
      repeat (5) @(posedge clk);
      #1;
      resp_rdy = 1'b1;
      wait_done(50);
      div_stall = 0;

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
